// File: rtl/regfile_sb_pkg.sv
// Shared widths and level constants for the decode-stage register file with scoreboard.
// Widths mirror the pipeline's RegBus / RegAddrBus buses.
package regfile_sb_pkg;

   localparam int RegBusW     = 32;
   localparam int RegAddrBusW = 5;

   localparam logic RstEnable   = 1'b1;
   localparam logic WriteEnable = 1'b1;
   localparam logic ReadEnable  = 1'b1;

endpackage

// File: rtl/regfile_rd_port.sv
// One combinational read slice: reset/zero-register masking, write bypass and
// busy lookup for a single read port.
module regfile_rd_port
   import regfile_sb_pkg::*;
#(
   parameter int DATA_W   = RegBusW,
   parameter int ADDR_W   = RegAddrBusW,
   parameter int ZERO_REG = 1
) (
   input  logic              rst,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   input  logic              we0,
   input  logic [ADDR_W-1:0] waddr0,
   input  logic [DATA_W-1:0] wdata0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] waddr1,
   input  logic [DATA_W-1:0] wdata1,
   input  logic [DATA_W-1:0] reg_data,
   input  logic              busy_bit,
   output logic [DATA_W-1:0] rdata,
   output logic              rbusy
);

   logic active;
   logic hit0;
   logic hit1;

   assign active = (rst != RstEnable) && (re == ReadEnable) &&
                   !((ZERO_REG != 0) && (raddr == '0));
   assign hit0   = (we0 == WriteEnable) && (waddr0 == raddr);
   assign hit1   = (we1 == WriteEnable) && (waddr1 == raddr);

   // A register being written this cycle is never reported busy: its data is bypassed.
   always_comb begin
      rdata = '0;
      rbusy = 1'b0;
      if (active) begin
         if (hit1) begin
            rdata = wdata1;
         end else if (hit0) begin
            rdata = wdata0;
         end else begin
            rdata = reg_data;
            rbusy = busy_bit;
         end
      end
   end

endmodule

// File: rtl/regfile_sb.sv
// Register file with N bypassed read ports, two write ports (port 1 wins) and a
// per-register busy scoreboard for hazard detection in decode.
module regfile_sb
   import regfile_sb_pkg::*;
#(
   parameter int DATA_W   = RegBusW,
   parameter int ADDR_W   = RegAddrBusW,
   parameter int NUM_RD   = 2,
   parameter int ZERO_REG = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     we0,
   input  logic [ADDR_W-1:0]        waddr0,
   input  logic [DATA_W-1:0]        wdata0,
   input  logic                     we1,
   input  logic [ADDR_W-1:0]        waddr1,
   input  logic [DATA_W-1:0]        wdata1,
   input  logic [NUM_RD-1:0]        re,
   input  logic [NUM_RD*ADDR_W-1:0] raddr,
   output logic [NUM_RD*DATA_W-1:0] rdata,
   output logic [NUM_RD-1:0]        rbusy,
   input  logic                     set_en,
   input  logic [ADDR_W-1:0]        set_addr,
   input  logic                     flush,
   output logic [2**ADDR_W-1:0]     busy_vec
);

   localparam int DEPTH = 2**ADDR_W;

   logic [DATA_W-1:0] regs_reg [DEPTH];
   logic [DEPTH-1:0]  busy_reg;
   logic [DEPTH-1:0]  busy_next;
   logic              wr0_ok;
   logic              wr1_ok;

   assign wr0_ok = (we0 == WriteEnable) && !((ZERO_REG != 0) && (waddr0 == '0));
   assign wr1_ok = (we1 == WriteEnable) && !((ZERO_REG != 0) && (waddr1 == '0));

   // Port 1 is assigned last so it wins a same-address collision.
   always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs_reg[i] <= '0;
         end
         busy_reg <= '0;
      end else begin
         if (wr0_ok) begin
            regs_reg[waddr0] <= wdata0;
         end
         if (wr1_ok) begin
            regs_reg[waddr1] <= wdata1;
         end
         busy_reg <= busy_next;
      end
   end

   // A newly issued producer supersedes a retiring one to the same register.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_busy
         if ((ZERO_REG != 0) && (gi == 0)) begin : g_zero
            assign busy_next[gi] = 1'b0;
         end else begin : g_bit
            logic set_hit;
            logic clr_hit;
            assign set_hit = set_en && (set_addr == ADDR_W'(gi));
            assign clr_hit = ((we0 == WriteEnable) && (waddr0 == ADDR_W'(gi))) ||
                             ((we1 == WriteEnable) && (waddr1 == ADDR_W'(gi)));
            assign busy_next[gi] = flush   ? 1'b0 :
                                   set_hit ? 1'b1 :
                                   clr_hit ? 1'b0 : busy_reg[gi];
         end
      end
   endgenerate

   assign busy_vec = busy_reg;

   generate
      for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
         logic [ADDR_W-1:0] addr_k;
         assign addr_k = raddr[gi*ADDR_W +: ADDR_W];

         regfile_rd_port #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .ZERO_REG (ZERO_REG)
         ) u_rd (
            .rst      (rst),
            .re       (re[gi]),
            .raddr    (addr_k),
            .we0      (we0),
            .waddr0   (waddr0),
            .wdata0   (wdata0),
            .we1      (we1),
            .waddr1   (waddr1),
            .wdata1   (wdata1),
            .reg_data (regs_reg[addr_k]),
            .busy_bit (busy_reg[addr_k]),
            .rdata    (rdata[gi*DATA_W +: DATA_W]),
            .rbusy    (rbusy[gi])
         );
      end
   endgenerate

endmodule

// File: tb/tb_regfile_sb.sv
// Directed plus randomized check of regfile_sb (4 read ports) against an
// array-based reference model of the register file and scoreboard.
module tb_regfile_sb;

   localparam int DW    = 32;
   localparam int AW    = 5;
   localparam int NR    = 4;
   localparam int DEPTH = 32;

   logic            clk = 1'b0;
   logic            rst;
   logic            we0, we1;
   logic [AW-1:0]   waddr0, waddr1;
   logic [DW-1:0]   wdata0, wdata1;
   logic [NR-1:0]   re;
   logic [NR*AW-1:0] raddr;
   logic [NR*DW-1:0] rdata;
   logic [NR-1:0]   rbusy;
   logic            set_en;
   logic [AW-1:0]   set_addr;
   logic            flush;
   logic [DEPTH-1:0] busy_vec;

   logic [DW-1:0]    m_regs [DEPTH];
   logic [DEPTH-1:0] m_busy;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   regfile_sb #(
      .DATA_W   (DW),
      .ADDR_W   (AW),
      .NUM_RD   (NR),
      .ZERO_REG (1)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .we0      (we0),
      .waddr0   (waddr0),
      .wdata0   (wdata0),
      .we1      (we1),
      .waddr1   (waddr1),
      .wdata1   (wdata1),
      .re       (re),
      .raddr    (raddr),
      .rdata    (rdata),
      .rbusy    (rbusy),
      .set_en   (set_en),
      .set_addr (set_addr),
      .flush    (flush),
      .busy_vec (busy_vec)
   );

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [AW-1:0] rd_addr(input int k);
      return raddr[k*AW +: AW];
   endfunction

   function automatic logic [DW-1:0] exp_rdata(input int k);
      logic [AW-1:0] a;
      a = rd_addr(k);
      if (rst || a == 0 || !re[k]) return '0;
      if (we1 && waddr1 == a) return wdata1;
      if (we0 && waddr0 == a) return wdata0;
      return m_regs[a];
   endfunction

   function automatic logic exp_rbusy(input int k);
      logic [AW-1:0] a;
      a = rd_addr(k);
      if (rst || a == 0 || !re[k]) return 1'b0;
      if ((we0 && waddr0 == a) || (we1 && waddr1 == a)) return 1'b0;
      return m_busy[a];
   endfunction

   task automatic set_rd(input int k, input logic [AW-1:0] a, input logic e);
      raddr[k*AW +: AW] = a;
      re[k] = e;
   endtask

   task automatic idle();
      rst = 0; we0 = 0; we1 = 0; waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0;
      re = '0; raddr = '0; set_en = 0; set_addr = '0; flush = 0;
   endtask

   // Checks combinational outputs for the inputs in place, clocks once,
   // advances the reference model and checks the registered scoreboard.
   task automatic tick();
      #2;
      for (int k = 0; k < NR; k++) begin
         chk($sformatf("rdata%0d a=%0d", k, rd_addr(k)), rdata[k*DW +: DW], exp_rdata(k));
         chk($sformatf("rbusy%0d a=%0d", k, rd_addr(k)), {31'b0, rbusy[k]}, {31'b0, exp_rbusy(k)});
      end
      @(posedge clk);
      if (rst) begin
         for (int r = 0; r < DEPTH; r++) m_regs[r] = '0;
         m_busy = '0;
      end else begin
         if (we0 && waddr0 != 0) m_regs[waddr0] = wdata0;
         if (we1 && waddr1 != 0) m_regs[waddr1] = wdata1;
         if (flush) begin
            m_busy = '0;
         end else begin
            if (we0) m_busy[waddr0] = 1'b0;
            if (we1) m_busy[waddr1] = 1'b0;
            if (set_en) m_busy[set_addr] = 1'b1;
            m_busy[0] = 1'b0;
         end
      end
      #1;
      chk("busy_vec", busy_vec, m_busy);
   endtask

   initial begin
      for (int r = 0; r < DEPTH; r++) m_regs[r] = '0;
      m_busy = '0;
      idle();

      // Reset: outputs masked while rst is high, state cleared after the edge.
      rst = 1; set_rd(0, 5'd3, 1); set_rd(1, 5'd9, 1); we0 = 1; waddr0 = 5'd3; wdata0 = 32'hDEAD_BEEF;
      #2 chk("rst_rdata0", rdata[0 +: DW], 32'h0);
      tick();
      chk("rst_busy_vec", busy_vec, 32'h0);

      // Every register reads zero after reset.
      for (int c = 0; c < DEPTH / NR; c++) begin
         idle();
         for (int k = 0; k < NR; k++) set_rd(k, AW'(c * NR + k), 1);
         tick();
      end

      // Write r3, read it back next cycle.
      idle(); we0 = 1; waddr0 = 5'd3; wdata0 = 32'h1234_5678; tick();
      idle(); set_rd(0, 5'd3, 1);
      #2 chk("r3_readback", rdata[0 +: DW], 32'h1234_5678);
      tick();

      // Dual-write collision on r7.
      idle(); we0 = 1; waddr0 = 5'd7; wdata0 = 32'hAAAA_AAAA;
      we1 = 1; waddr1 = 5'd7; wdata1 = 32'h5555_5555; set_rd(1, 5'd7, 1);
      #2 chk("r7_bypass", rdata[DW +: DW], 32'h5555_5555);
      tick();
      idle(); set_rd(1, 5'd7, 1);
      #2 chk("r7_stored", rdata[DW +: DW], 32'h5555_5555);
      tick();

      // Zero register ignores writes and busy.
      idle(); we0 = 1; waddr0 = 5'd0; wdata0 = 32'hFFFF_FFFF; set_en = 1; set_addr = 5'd0; tick();
      idle(); set_rd(0, 5'd0, 1);
      #2 chk("r0_read", rdata[0 +: DW], 32'h0);
      chk("r0_rbusy", {31'b0, rbusy[0]}, 32'h0);
      chk("r0_busy_vec", {31'b0, busy_vec[0]}, 32'h0);
      tick();

      // Scoreboard lifecycle on r9.
      idle(); set_en = 1; set_addr = 5'd9; tick();
      idle(); set_rd(0, 5'd9, 1);
      #2 chk("r9_busy_t1", {31'b0, rbusy[0]}, 32'h1);
      tick();
      idle(); set_rd(0, 5'd9, 1); tick();
      idle(); set_rd(0, 5'd9, 1); we0 = 1; waddr0 = 5'd9; wdata0 = 32'h0BAD_F00D;
      #2 chk("r9_bypass_clear", {31'b0, rbusy[0]}, 32'h0);
      tick();
      chk("r9_busy_vec_t4", {31'b0, busy_vec[9]}, 32'h0);

      // Set beats clear; flush beats set.
      idle(); set_en = 1; set_addr = 5'd4; we1 = 1; waddr1 = 5'd4; wdata1 = 32'h4444_4444; tick();
      chk("r4_set_wins", {31'b0, busy_vec[4]}, 32'h1);
      idle(); flush = 1; set_en = 1; set_addr = 5'd5; tick();
      chk("flush_all_zero", busy_vec, 32'h0);

      // Four ports: r1, r2 (being written), r0, r1 with re=0.
      idle(); we0 = 1; waddr0 = 5'd1; wdata0 = 32'h1111_0001; tick();
      idle(); we0 = 1; waddr0 = 5'd2; wdata0 = 32'h2222_0002;
      set_rd(0, 5'd1, 1); set_rd(1, 5'd2, 1); set_rd(2, 5'd0, 1); set_rd(3, 5'd1, 0);
      #2 chk("p0_r1", rdata[0 +: DW], 32'h1111_0001);
      chk("p1_r2_bypass", rdata[DW +: DW], 32'h2222_0002);
      chk("p2_r0", rdata[2*DW +: DW], 32'h0);
      chk("p3_disabled", rdata[3*DW +: DW], 32'h0);
      tick();

      // Randomized traffic over a small address window to force collisions.
      for (int n = 0; n < 500; n++) begin
         rst      = ($urandom_range(0, 39) == 0);
         flush    = ($urandom_range(0, 15) == 0);
         we0      = 1'($urandom);
         waddr0   = AW'($urandom_range(0, 7));
         wdata0   = $urandom;
         we1      = 1'($urandom);
         waddr1   = AW'($urandom_range(0, 7));
         wdata1   = $urandom;
         set_en   = 1'($urandom);
         set_addr = AW'($urandom_range(0, 7));
         for (int k = 0; k < NR; k++) set_rd(k, AW'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0));
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
